l2_arbiter: RTL



---
 rtl/lc3b_types.sv | 23 ++
 rtl/l2_arbiter_control.sv | 72 +++++++
 rtl/l2_arbiter.sv | 96 +++++++++
 3 files changed

// File: rtl/lc3b_types.sv
`default_nettype none
// ============================================================================
// Module   : lc3b_types
// Purpose  : Shared types for the LC-3b memory hierarchy (word, line, arbiter)
// Revision : 1.0 - initial release
// ============================================================================
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  typedef enum logic {
    ARB_I = 1'b0,
    ARB_D = 1'b1
  } arb_sel;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } arb_op;

endpackage
`default_nettype wire

// File: rtl/l2_arbiter_control.sv
`default_nettype none
// ============================================================================
// Module   : l2_arbiter_control
// Purpose  : Round-robin grant FSM for the shared L2 port; owns last_grant
// Revision : 1.0 - initial release
// ============================================================================
module l2_arbiter_control
  import lc3b_types::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   i_req,
  input  logic   d_req,
  input  logic   l2_resp,
  output logic   latch_en,
  output arb_sel grant_sel,
  output logic   serve_i,
  output logic   serve_d
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t state_q, state_d;
  arb_sel last_grant_q, last_grant_d;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    latch_en     = 1'b0;
    grant_sel    = ARB_I;
    case (state_q)
      IDLE: begin
        // On a tie the side that did not win last time gets the port.
        if (i_req && d_req) begin
          if (last_grant_q == ARB_I) grant_sel = ARB_D;
          else                       grant_sel = ARB_I;
        end else if (d_req) begin
          grant_sel = ARB_D;
        end
        if (i_req || d_req) begin
          latch_en     = 1'b1;
          last_grant_d = grant_sel;
          if (grant_sel == ARB_D) state_d = SERVE_D;
          else                    state_d = SERVE_I;
        end
      end
      SERVE_I, SERVE_D: begin
        if (l2_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= ARB_I;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign serve_i = (state_q == SERVE_I);
  assign serve_d = (state_q == SERVE_D);

endmodule
`default_nettype wire

// File: rtl/l2_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : l2_arbiter
// Purpose  : Arbitrates split L1 I/D line requests onto the single L2 port
// Revision : 1.0 - initial release
// ============================================================================
module l2_arbiter
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     i_read,
  input  logic     i_write,
  input  lc3b_word i_address,
  input  lc3b_line i_wdata,
  output logic     i_resp,
  output lc3b_line i_rdata,
  input  logic     d_read,
  input  logic     d_write,
  input  lc3b_word d_address,
  input  lc3b_line d_wdata,
  output logic     d_resp,
  output lc3b_line d_rdata,
  output logic     l2_read,
  output logic     l2_write,
  output lc3b_word l2_address,
  output lc3b_line l2_wdata,
  input  logic     l2_resp,
  input  lc3b_line l2_rdata
);

  logic   latch_en;
  arb_sel grant_sel;
  logic   serve_i;
  logic   serve_d;
  logic   busy;

  lc3b_word req_addr_q, req_addr_d;
  lc3b_line req_wdata_q, req_wdata_d;
  arb_op    req_op_q, req_op_d;

  l2_arbiter_control u_control (
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_read | i_write),
    .d_req     (d_read | d_write),
    .l2_resp   (l2_resp),
    .latch_en  (latch_en),
    .grant_sel (grant_sel),
    .serve_i   (serve_i),
    .serve_d   (serve_d)
  );

  // Write wins when a requester raises read and write together.
  always_comb begin
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_op_d    = req_op_q;
    if (latch_en) begin
      if (grant_sel == ARB_D) begin
        req_addr_d  = d_address;
        req_wdata_d = d_wdata;
        req_op_d    = d_write ? OP_WRITE : OP_READ;
      end else begin
        req_addr_d  = i_address;
        req_wdata_d = i_wdata;
        req_op_d    = i_write ? OP_WRITE : OP_READ;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_op_q    <= OP_READ;
    end else begin
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_op_q    <= req_op_d;
    end
  end

  assign busy       = serve_i | serve_d;
  assign l2_read    = busy && (req_op_q == OP_READ);
  assign l2_write   = busy && (req_op_q == OP_WRITE);
  assign l2_address = req_addr_q;
  assign l2_wdata   = req_wdata_q;

  assign i_resp  = serve_i & l2_resp;
  assign d_resp  = serve_d & l2_resp;
  assign i_rdata = l2_rdata;
  assign d_rdata = l2_rdata;

endmodule
`default_nettype wire
